// File: rtl/ct_lsu_dcache_data_arb.sv
// Data-bank arbiter for one dcache slice: picks one of refill/store/load per cycle,
// registers the winner onto the SRAM pins and returns load data two cycles after grant.
module ct_lsu_dcache_data_arb #(
    parameter int IDX_W        = 11,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             rf_req,
    input  logic [IDX_W-1:0] rf_idx,
    input  logic [31:0]      rf_din,
    input  logic [3:0]       rf_be,
    output logic             rf_grnt,
    input  logic             st_req,
    input  logic [IDX_W-1:0] st_idx,
    input  logic [31:0]      st_din,
    input  logic [3:0]       st_be,
    output logic             st_grnt,
    input  logic             ld_req,
    input  logic [IDX_W-1:0] ld_idx,
    output logic             ld_grnt,
    input  logic             ld_cancel,
    output logic             ld_data_vld,
    output logic [31:0]      ld_data,
    output logic             data_gateclk_en,
    output logic             data_sel_b,
    output logic             data_gwen_b,
    output logic [3:0]       data_wen_b,
    output logic [IDX_W-1:0] data_idx,
    output logic [31:0]      data_din,
    input  logic [31:0]      data_dout
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]       st_wait_q, st_wait_d;
    logic [3:0]       ld_wait_q, ld_wait_d;
    logic             cmd_vld_q, cmd_vld_d;
    logic             is_ld_q, is_ld_d;
    logic             gwen_b_q, gwen_b_d;
    logic [3:0]       wen_b_q, wen_b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      din_q, din_d;
    logic             rd_vld_q, rd_vld_d;
    logic             st_prom, ld_prom;

    assign st_prom = (st_wait_q == LIMIT);
    assign ld_prom = (ld_wait_q == LIMIT);

    // Promoted requesters jump ahead of refill; otherwise refill > store > load.
    always_comb begin
        rf_grnt = 1'b0;
        st_grnt = 1'b0;
        ld_grnt = 1'b0;
        if (st_req && st_prom)      st_grnt = 1'b1;
        else if (ld_req && ld_prom) ld_grnt = 1'b1;
        else if (rf_req)            rf_grnt = 1'b1;
        else if (st_req)            st_grnt = 1'b1;
        else if (ld_req)            ld_grnt = 1'b1;
    end

    always_comb begin
        st_wait_d = 4'd0;
        ld_wait_d = 4'd0;
        if (st_req && !st_grnt) st_wait_d = (st_wait_q == LIMIT) ? LIMIT : st_wait_q + 4'd1;
        if (ld_req && !ld_grnt) ld_wait_d = (ld_wait_q == LIMIT) ? LIMIT : ld_wait_q + 4'd1;
    end

    // A write with no byte enables is granted but never reaches the SRAM.
    always_comb begin
        cmd_vld_d = 1'b0;
        is_ld_d   = 1'b0;
        gwen_b_d  = 1'b1;
        wen_b_d   = 4'hf;
        idx_d     = idx_q;
        din_d     = din_q;
        if (rf_grnt && rf_be != 4'h0) begin
            cmd_vld_d = 1'b1;
            gwen_b_d  = 1'b0;
            wen_b_d   = ~rf_be;
            idx_d     = rf_idx;
            din_d     = rf_din;
        end else if (st_grnt && st_be != 4'h0) begin
            cmd_vld_d = 1'b1;
            gwen_b_d  = 1'b0;
            wen_b_d   = ~st_be;
            idx_d     = st_idx;
            din_d     = st_din;
        end else if (ld_grnt) begin
            cmd_vld_d = 1'b1;
            is_ld_d   = 1'b1;
            idx_d     = ld_idx;
        end
        rd_vld_d = cmd_vld_q & is_ld_q & ~ld_cancel;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            st_wait_q <= 4'd0;
            ld_wait_q <= 4'd0;
            cmd_vld_q <= 1'b0;
            is_ld_q   <= 1'b0;
            gwen_b_q  <= 1'b1;
            wen_b_q   <= 4'hf;
            idx_q     <= '0;
            din_q     <= 32'd0;
            rd_vld_q  <= 1'b0;
        end else begin
            st_wait_q <= st_wait_d;
            ld_wait_q <= ld_wait_d;
            cmd_vld_q <= cmd_vld_d;
            is_ld_q   <= is_ld_d;
            gwen_b_q  <= gwen_b_d;
            wen_b_q   <= wen_b_d;
            idx_q     <= idx_d;
            din_q     <= din_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign data_gateclk_en = cmd_vld_q;
    assign data_sel_b      = ~cmd_vld_q;
    assign data_gwen_b     = gwen_b_q;
    assign data_wen_b      = wen_b_q;
    assign data_idx        = idx_q;
    assign data_din        = din_q;
    assign ld_data_vld     = rd_vld_q;
    assign ld_data         = data_dout;

endmodule

// File: doc/ct_lsu_dcache_data_arb.md
# ct_lsu_dcache_data_arb

Arbiter and command sequencer for one dcache data bank (32-bit-wide single-port SRAM slice behind a gated clock). It shares the bank between three requesters (refill, store and load) and registers the winning command onto the SRAM pins. It drives the bank clock-gate enable and returns load read data with a valid strobe. It sits in the LSU between the linefill/store/load pipes and the data array instance, one copy per bank.

## Interface
Parameters:
- IDX_W, 11, data array index width (10 for 32K dcache, 11 for 64K)
- STARVE_LIMIT, 8, consecutive denied cycles before a store/load requester is promoted (2..15)

Ports:
- forever_cpuclk  in  1  clock; one clock, all flops on rising edge
- cpurst_b  in  1  reset, asynchronous, active-low
- rf_req / rf_idx / rf_din / rf_be  in  1 / IDX_W / 32 / 4  refill write request, index, data, active-high byte enables
- rf_grnt  out  1  refill granted this cycle
- st_req / st_idx / st_din / st_be  in  1 / IDX_W / 32 / 4  store write request
- st_grnt  out  1  store granted this cycle
- ld_req / ld_idx  in  1 / IDX_W  load read request
- ld_grnt  out  1  load granted this cycle
- ld_cancel  in  1  kill the load currently in the command stage
- ld_data_vld  out  1  load read data valid
- ld_data  out  32  load read data (data_dout passthrough)
- data_gateclk_en  out  1  bank clock-gate local enable
- data_sel_b / data_gwen_b  out  1 / 1  SRAM chip select / global write enable, active-low
- data_wen_b  out  4  per-byte write enable, active-low
- data_idx / data_din  out  IDX_W / 32  SRAM index / write data
- data_dout  in  32  SRAM read data, valid cycle after the SRAM sampling edge

## Operation
- Grant is combinational, at most one per cycle. Base priority is refill > store > load.
- Starvation counters st_wait and ld_wait are 4 bits each.
  - A counter increments each cycle its req=1 and its grnt=0, saturating at STARVE_LIMIT.
  - A counter clears on grant or req=0.
- A requester whose counter equals STARVE_LIMIT is promoted above refill. If both are promoted, store wins over load.
- A granted command loads the command register (cmd_vld, idx, din, wen_b, gwen_b, is_ld) at the clock edge.
- No grant: cmd_vld<=0, and the SRAM pins return to idle: sel_b=1, gwen_b=1, wen_b=4'hf. idx and din hold their last value.
- Write command: sel_b=0, gwen_b=0, wen_b=~be.
- Write with be=4'h0: the grant is still given and the counter cleared, but cmd_vld<=0 and the SRAM is not selected.
- Read command: sel_b=0, gwen_b=1, wen_b=4'hf.
- data_gateclk_en = cmd_vld (registered; the ICG passes the edge closing the command cycle).
- Load return flop: rd_vld<=cmd_vld & is_ld & ~ld_cancel.
  - ld_data_vld=rd_vld.
  - ld_data=data_dout, unregistered.
- Requesters hold req/idx/data stable until granted. The block does not buffer ungranted requests.

## Timing
- Cycle T: req=1 and grnt=1.
- T+1: command on SRAM pins and data_gateclk_en=1. The SRAM samples at the end of T+1.
- T+2: ld_data_vld=1 with data_dout for loads.
- Load latency is 2 cycles grant-to-data. Writes are complete at the end of T+1.
- Back-to-back grants every cycle give a throughput of 1 access/cycle. A write immediately after a read to the same index does not disturb the pending read return.
- ld_cancel is sampled only in T+1 of a load. Outside that cycle it is ignored.
- Reset values: all grnt=0, ld_data_vld=0, data_gateclk_en=0, data_sel_b=1, data_gwen_b=1, data_wen_b=4'hf, data_idx=0, data_din=0, st_wait=ld_wait=0.
- Reset asserted mid-operation clears the command and return flops asynchronously. An in-flight load returns no ld_data_vld.
- Because grant is combinational, a requester raising req in the same cycle as reset deassertion may be granted in that cycle.

## Test plan
- Single load idx=0x155 after a store of 0x A5A5_5A5A be=4'hf to 0x155 -> ld_grnt at T, data_sel_b=0/gwen_b=1 at T+1, ld_data_vld=1 and ld_data=0xA5A5_5A5A at T+2.
- All three req in the same cycle -> rf_grnt=1 at T, st_grnt at T+1, ld_grnt at T+2. data_wen_b is 4'h0, 4'h0 (full writes) then 4'hf.
- rf_req held 20 cycles with st_req held (STARVE_LIMIT=8) -> st_grnt in the 9th cycle of st_req (1 refill grant then 8 denied, promoted), st_wait back to 0, refill resumes next cycle.
- Store be=4'b0101 din=0x1122_3344 -> data_wen_b=4'b1010 at T+1. A later read returns the new bytes 0 and 2 with bytes 1 and 3 unchanged. A store with be=4'h0 -> st_grnt=1, data_sel_b stays 1.
- Load granted, then ld_cancel=1 in T+1 -> SRAM still read, ld_data_vld=0 at T+2. Second load granted at T+1 -> its ld_data_vld=1 at T+3.
- Load granted, cpurst_b low in T+1 -> all outputs at reset values immediately, no ld_data_vld after reset release.
